rmii_rx_framer: RTL and testbench

- Receive-side RMII front end in clk_50. Sits directly downstream of the RMII PHY pins (i_erxd, i_erx_dv, i_erx_er) and upstream of the MAC receive buffer.
- Strips preamble and SFD, then assembles LSB-first dibits into bytes.
- Checks CRC-32 over the frame and reports per-frame length and status.
- Delivers a byte stream with start/end markers to the shared packet RAM writer.

---
 rtl/eth_rmii_pkg.sv | 23 ++
 rtl/crc32_byte.sv | 20 ++
 rtl/rmii_rx_framer.sv | 138 +++++++++++++
 tb/tb_rmii_rx_framer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_rmii_pkg.sv
// Shared RMII receive definitions: framer states, preamble/SFD dibits and CRC-32 constants.
package eth_rmii_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } rx_state_e;

  localparam logic [1:0]  RMII_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  RMII_SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC32_POLY_REFL     = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT          = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE_DEFAULT = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational byte-wide step of the reflected CRC-32 (LSB-first bit order).
module crc32_byte
  import eth_rmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, assembles LSB-first dibits into bytes,
// checks the CRC-32 residue and reports per-frame length and status.
module rmii_rx_framer
  import eth_rmii_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 2047,
  parameter logic [31:0] CRC_RESIDUE = CRC_RESIDUE_DEFAULT
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [1:0]  i_erxd,
  input  logic        i_erx_dv,
  input  logic        i_erx_er,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [10:0] rx_len,
  output logic        rx_fcs_ok,
  output logic        rx_err,
  output logic        rx_busy
);

  localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);

  rx_state_e   state, state_nxt;
  logic [1:0]  d;
  logic        dv, er;
  logic [1:0]  cnt;
  logic [5:0]  shreg;
  logic [31:0] crc, crc_next;
  logic [10:0] len;
  logic        err_flag, first;
  logic        start_frame, take_dibit, frame_end, dribble;
  logic [7:0]  byte_cur;

  assign byte_cur = {d, shreg};
  assign rx_busy  = (state != IDLE);

  crc32_byte u_crc (
    .crc_in  (crc),
    .data    (byte_cur),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A low CRS_DV at counter 2 is carrier-loss toggling, so that dibit is still data.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    take_dibit  = 1'b0;
    frame_end   = 1'b0;
    dribble     = 1'b0;
    case (state)
      IDLE: begin
        if (dv && d == RMII_PREAMBLE_DIBIT) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        if (!dv) state_nxt = IDLE;
        else if (d == RMII_SFD_DIBIT) begin
          state_nxt   = DATA;
          start_frame = 1'b1;
        end else if (d != RMII_PREAMBLE_DIBIT) state_nxt = IDLE;
      end
      DATA: begin
        if (dv || cnt == 2'd2) take_dibit = 1'b1;
        else begin
          frame_end = 1'b1;
          dribble   = (cnt != 2'd0);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      d         <= '0;
      dv        <= 1'b0;
      er        <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      crc       <= CRC32_INIT;
      len       <= '0;
      err_flag  <= 1'b0;
      first     <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_len    <= '0;
      rx_fcs_ok <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      d        <= i_erxd;
      dv       <= i_erx_dv;
      er       <= i_erx_er;
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      if (start_frame) begin
        cnt      <= '0;
        crc      <= CRC32_INIT;
        len      <= '0;
        err_flag <= 1'b0;
        first    <= 1'b1;
      end
      if (take_dibit) begin
        // Right shift places dibit n at bits [2n+1:2n] once three have arrived.
        shreg <= {d, shreg[5:2]};
        cnt   <= cnt + 2'd1;
        if (er) err_flag <= 1'b1;
        if (cnt == 2'd3) begin
          rx_data  <= byte_cur;
          rx_valid <= 1'b1;
          rx_sof   <= first;
          first    <= 1'b0;
          crc      <= crc_next;
          if (len == LEN_MAX) err_flag <= 1'b1;
          else                len      <= len + 11'd1;
        end
      end
      if (frame_end) begin
        rx_eof    <= 1'b1;
        rx_len    <= len;
        // The register is kept in reflected order; the residue constant is in normal order.
        rx_fcs_ok <= (bitrev32(crc) == CRC_RESIDUE) && (len >= 11'd4);
        rx_err    <= err_flag | dribble | er;
      end
    end
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Self-checking bench for rmii_rx_framer: table of frame scenarios plus a reset-mid-frame sequence.
module tb_rmii_rx_framer;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic [1:0]  i_erxd;
  logic        i_erx_dv;
  logic        i_erx_er;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [10:0] rx_len;
  logic        rx_fcs_ok;
  logic        rx_err;
  logic        rx_busy;

  rmii_rx_framer #(.MAX_LEN(2047), .CRC_RESIDUE(32'hC704DD7B)) dut (
    .clk_50    (clk_50),
    .rst       (rst),
    .i_erxd    (i_erxd),
    .i_erx_dv  (i_erx_dv),
    .i_erx_er  (i_erx_er),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_len    (rx_len),
    .rx_fcs_ok (rx_fcs_ok),
    .rx_err    (rx_err),
    .rx_busy   (rx_busy)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    int unsigned plen;
    bit          fcs;
    bit          bad;
    int          er_at;
    bit          drop;
    bit          crs;
    int unsigned e_len;
    bit          e_ok;
    bit          e_err;
  } vec_t;

  typedef struct { logic [7:0] data; logic sof; } exp_byte_t;
  typedef struct { logic [10:0] len; logic ok; logic err; } exp_eof_t;

  exp_byte_t exp_b[$];
  exp_eof_t  exp_e[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  always @(negedge clk_50) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_b.size() == 0) chk("unexpected_valid", {24'h0, rx_data}, 32'hFFFFFFFF);
        else begin
          exp_byte_t e;
          e = exp_b.pop_front();
          chk("rx_data", {24'h0, rx_data}, {24'h0, e.data});
          chk("rx_sof", {31'h0, rx_sof}, {31'h0, e.sof});
        end
      end
      if (rx_eof) begin
        chk("eof_without_valid", {31'h0, rx_valid}, 32'h0);
        if (exp_e.size() == 0) chk("unexpected_eof", {21'h0, rx_len}, 32'hFFFFFFFF);
        else begin
          exp_eof_t f;
          f = exp_e.pop_front();
          chk("rx_len", {21'h0, rx_len}, {21'h0, f.len});
          chk("rx_fcs_ok", {31'h0, rx_fcs_ok}, {31'h0, f.ok});
          chk("rx_err", {31'h0, rx_err}, {31'h0, f.err});
        end
      end
    end
  end

  task automatic dibit(input logic [1:0] dd, input logic v, input logic e);
    @(negedge clk_50);
    i_erxd   = dd;
    i_erx_dv = v;
    i_erx_er = e;
  endtask

  task automatic send_preamble();
    for (int k = 0; k < 31; k++) dibit(2'b01, 1'b1, 1'b0);
    dibit(2'b11, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) dibit(2'b00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0]  fr[$];
    logic [31:0] c;
    logic [7:0]  b;
    logic        pdv;
    int          n;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < int'(v.plen); k++) begin
      b = k[7:0];
      fr.push_back(b);
      c = crc_step(c, b);
    end
    if (v.fcs) begin
      c = ~c;
      fr.push_back(c[7:0]);
      fr.push_back(c[15:8]);
      fr.push_back(c[23:16]);
      fr.push_back(c[31:24]);
      if (v.bad) fr[v.plen] = fr[v.plen] ^ 8'h01;
    end
    n = fr.size();
    for (int k = 0; k < n - (v.drop ? 1 : 0); k++) exp_b.push_back('{fr[k], k == 0});
    exp_e.push_back('{v.e_len[10:0], v.e_ok, v.e_err});
    send_preamble();
    for (int k = 0; k < n; k++) begin
      b = fr[k];
      for (int j = 0; j < 4; j++) begin
        if (!(v.drop && k == n - 1 && j == 3)) begin
          pdv = !(v.crs && k >= n - 3 && j == 2);
          dibit(b[2*j +: 2], pdv, (k == v.er_at) && (j == 1));
        end
      end
    end
    idle(12);
    chk("bytes_left", exp_b.size(), 0);
    chk("eof_left", exp_e.size(), 0);
    chk("busy_after_frame", {31'h0, rx_busy}, 32'h0);
    exp_b.delete();
    exp_e.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  {24'h0, rx_data}, 32'h0);
    chk({tag, "_valid"}, {31'h0, rx_valid}, 32'h0);
    chk({tag, "_sof"},   {31'h0, rx_sof}, 32'h0);
    chk({tag, "_eof"},   {31'h0, rx_eof}, 32'h0);
    chk({tag, "_len"},   {21'h0, rx_len}, 32'h0);
    chk({tag, "_ok"},    {31'h0, rx_fcs_ok}, 32'h0);
    chk({tag, "_err"},   {31'h0, rx_err}, 32'h0);
    chk({tag, "_busy"},  {31'h0, rx_busy}, 32'h0);
  endtask

  initial begin
    logic [7:0] b;
    //            plen fcs bad er_at drop crs  len  ok err
    tbl[0] = '{  60, 1, 0,  -1, 0, 0,   64, 1, 0};
    tbl[1] = '{  60, 1, 1,  -1, 0, 0,   64, 0, 0};
    tbl[2] = '{  60, 1, 0,  20, 0, 0,   64, 1, 1};
    tbl[3] = '{  60, 1, 0,  -1, 1, 0,   63, 0, 1};
    tbl[4] = '{  60, 1, 0,  -1, 0, 1,   64, 1, 0};
    tbl[5] = '{   0, 1, 0,  -1, 0, 0,    4, 1, 0};
    tbl[6] = '{   3, 0, 0,  -1, 0, 0,    3, 0, 0};
    tbl[7] = '{2046, 1, 0,  -1, 0, 0, 2047, 1, 1};

    rst = 1'b1; i_erxd = 2'b00; i_erx_dv = 1'b0; i_erx_er = 1'b0;
    repeat (3) @(negedge clk_50);
    chk_all_zero("in_reset");
    rst = 1'b0;
    idle(4);
    chk_all_zero("after_reset");

    for (int t = 0; t < 8; t++) send_frame(tbl[t]);

    // back-to-back: frame 1, then reset in the middle of frame 2, then frame 3
    send_frame(tbl[0]);
    send_preamble();
    for (int k = 0; k < 10; k++) begin
      b = 8'h80 + k[7:0];
      exp_b.push_back('{b, k == 0});
      for (int j = 0; j < 4; j++) dibit(b[2*j +: 2], 1'b1, 1'b0);
    end
    dibit(2'b10, 1'b1, 1'b0);
    dibit(2'b01, 1'b1, 1'b0);
    @(negedge clk_50);
    rst = 1'b1; i_erx_dv = 1'b0; i_erxd = 2'b00;
    @(negedge clk_50);
    chk_all_zero("mid_reset");
    chk("partial_bytes_left", exp_b.size(), 0);
    repeat (2) @(negedge clk_50);
    rst = 1'b0;
    idle(8);
    chk_all_zero("post_reset");
    exp_b.delete();
    send_frame(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
